// File: rtl/alu_pkg.sv
// alu_pkg: shared types and constants for the ALU result path.
//   - NZCV flag bit positions inside a 4-bit flag vector
//   - alu_flags_t / alu_entry_t: one queued ALU result {sel, y, flags} (40 bits)
//   - ALU opcode constants
package alu_pkg;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef logic [3:0] alu_flags_t;

  typedef struct packed {
    logic [3:0]  sel;
    logic [31:0] y;
    alu_flags_t  flags;
  } alu_entry_t;

  localparam logic [3:0] SEL_AND  = 4'b0000;
  localparam logic [3:0] SEL_OR   = 4'b0001;
  localparam logic [3:0] SEL_XOR  = 4'b0010;
  localparam logic [3:0] SEL_ADD  = 4'b0011;
  localparam logic [3:0] SEL_SUB  = 4'b0100;
  localparam logic [3:0] SEL_NAND = 4'b0101;

  // Pack individual ALU flag outputs into {N,Z,C,V} order.
  function automatic alu_flags_t pack_flags(input logic n, input logic z,
                                            input logic c, input logic v);
    alu_flags_t f;
    f         = '0;
    f[FLAG_N] = n;
    f[FLAG_Z] = z;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/alu_rb_mem.sv
// alu_rb_mem: DEPTH x 40-bit storage for queued ALU results.
//   clk     : clock, write on rising edge
//   i_we    : write enable
//   i_waddr : write address
//   i_wdata : entry to store
//   i_raddr : read address
//   o_rdata : entry at i_raddr (combinational read, no read latency)
// Storage carries no reset; the top masks outputs while the queue is empty.
module alu_rb_mem
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  alu_entry_t    i_wdata,
  input  logic [AW-1:0] i_raddr,
  output alu_entry_t    o_rdata
);

  alu_entry_t r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/alu_result_buffer.sv
// alu_result_buffer: queues ALU results {sel, y, NZCV} in a DEPTH-entry FIFO
// between the combinational ALU and slower writeback/branch logic, and keeps
// an architectural NZCV register loaded from each entry as it is popped.
//   clk, rst_n          : clock (rising edge), async active-low reset
//   flush               : synchronous clear of the queue (flag_reg kept)
//   in_valid/in_ready   : producer handshake; in_ready = not full
//   in_y/in_sel         : ALU result and opcode
//   in_cout/in_neg/in_zero/in_ovf : ALU flags
//   out_valid/out_ready : consumer handshake; out_valid = not empty
//   out_y/out_sel/out_flags : head entry, zero while empty
//   count               : occupancy 0..DEPTH
//   flag_reg            : {N,Z,C,V} of the last popped entry
//   ovf_sticky/clr_sticky : sticky overflow and its clear
// Build option: define ALU_OVF_STICKY_EN to enable the sticky overflow bit;
// otherwise ovf_sticky is tied to 0 and clr_sticky is ignored.
module alu_result_buffer
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_y,
  input  logic [3:0]    in_sel,
  input  logic          in_cout,
  input  logic          in_neg,
  input  logic          in_zero,
  input  logic          in_ovf,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_y,
  output logic [3:0]    out_sel,
  output logic [3:0]    out_flags,
  output logic [AW:0]   count,
  output logic [3:0]    flag_reg,
  output logic          ovf_sticky,
  input  logic          clr_sticky
);

  localparam logic [AW:0] L_FULL = (AW + 1)'(DEPTH);

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  alu_flags_t    r_flag;

  logic          w_push;
  logic          w_pop;
  logic          w_push_eff;
  logic          w_pop_eff;
  alu_entry_t    w_wr_entry;
  alu_entry_t    w_rd_entry;

  assign in_ready  = (r_count != L_FULL);
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;
  // A flush discards any handshake in the same cycle.
  assign w_push_eff = w_push & ~flush;
  assign w_pop_eff  = w_pop & ~flush;

  assign w_wr_entry.sel   = in_sel;
  assign w_wr_entry.y     = in_y;
  assign w_wr_entry.flags = pack_flags(in_neg, in_zero, in_cout, in_ovf);

  alu_rb_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_push_eff),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_wr_entry),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rd_entry)
  );

  // Head entry is undefined storage while empty; present zeros instead.
  assign out_y     = out_valid ? w_rd_entry.y     : '0;
  assign out_sel   = out_valid ? w_rd_entry.sel   : '0;
  assign out_flags = out_valid ? w_rd_entry.flags : '0;

  assign count    = r_count;
  assign flag_reg = r_flag;

  // Pointers wrap naturally at DEPTH because DEPTH == 2**AW.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flag <= '0;
    end else if (w_pop_eff) begin
      r_flag <= w_rd_entry.flags;
    end
  end

`ifdef ALU_OVF_STICKY_EN
  logic r_ovf_sticky;

  // Set has priority over clear in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf_sticky <= 1'b0;
    end else if (w_push_eff && in_ovf) begin
      r_ovf_sticky <= 1'b1;
    end else if (clr_sticky) begin
      r_ovf_sticky <= 1'b0;
    end
  end

  assign ovf_sticky = r_ovf_sticky;
`else
  logic w_unused_clr;
  assign w_unused_clr = clr_sticky;
  assign ovf_sticky   = 1'b0;
`endif

endmodule

// File: tb/tb_alu_result_buffer.sv
// Randomized scoreboard bench for alu_result_buffer. The reference is a plain
// queue of expected entries: accepted pushes append, observed pops take from
// the front, flush empties it. Status outputs are compared after every edge.
module tb_alu_result_buffer;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  typedef struct {
    logic [3:0]  sel;
    logic [31:0] y;
    logic [3:0]  f;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_y = '0;
  logic [3:0]  in_sel = '0;
  logic        in_cout = 1'b0;
  logic        in_neg = 1'b0;
  logic        in_zero = 1'b0;
  logic        in_ovf = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_y;
  logic [3:0]  out_sel;
  logic [3:0]  out_flags;
  logic [AW:0] count;
  logic [3:0]  flag_reg;
  logic        ovf_sticky;
  logic        clr_sticky = 1'b0;

  alu_result_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_y       (in_y),
    .in_sel     (in_sel),
    .in_cout    (in_cout),
    .in_neg     (in_neg),
    .in_zero    (in_zero),
    .in_ovf     (in_ovf),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_y      (out_y),
    .out_sel    (out_sel),
    .out_flags  (out_flags),
    .count      (count),
    .flag_reg   (flag_reg),
    .ovf_sticky (ovf_sticky),
    .clr_sticky (clr_sticky)
  );

  always #5 clk = ~clk;

  exp_t       exp_q[$];
  logic [3:0] exp_flag = '0;
  logic       exp_sticky = 1'b0;
  logic       pend_sticky = 1'b0;
  logic       last_flush = 1'b0;
  int         vectors = 0;
  int         miscompares = 0;
  int         pops_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a pop happens at the coming edge; compare head with scoreboard.
  always @(negedge clk) begin
    if (rst_n && !flush && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL pop_empty: DUT popped with no expected entry at %0t", $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("pop_y", out_y, e.y);
        check("pop_sel", {28'd0, out_sel}, {28'd0, e.sel});
        check("pop_flags", {28'd0, out_flags}, {28'd0, e.f});
        $display("pop  y=%08h sel=%0h nzcv=%04b", out_y, out_sel, out_flags);
        exp_flag = e.f;
        pops_seen++;
      end
    end
  end

  // Called 2 time units after a rising edge: check status, then drive next cycle.
  task automatic cycle(input int pv, input int pr, input int pf, input int pc);
    logic push;
    if (last_flush) exp_q.delete();
    exp_sticky = pend_sticky;
    check("count", {29'd0, count}, exp_q.size());
    check("in_ready", {31'd0, in_ready}, {31'd0, exp_q.size() != DEPTH});
    check("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() != 0});
    check("flag_reg", {28'd0, flag_reg}, {28'd0, exp_flag});
    check("ovf_sticky", {31'd0, ovf_sticky}, {31'd0, exp_sticky});
    if (exp_q.size() == 0) begin
      check("empty_out", {out_y[27:0] | {24'd0, out_flags}, out_sel}, 32'd0);
    end

    in_valid   = ($urandom_range(0, 99) < pv);
    out_ready  = ($urandom_range(0, 99) < pr);
    flush      = ($urandom_range(0, 99) < pf);
    clr_sticky = ($urandom_range(0, 99) < pc);
    in_y       = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
    in_sel     = 4'($urandom_range(0, 5));
    {in_neg, in_zero, in_cout, in_ovf} = 4'($urandom_range(0, 15));

    push = in_valid && (exp_q.size() < DEPTH);
    if (push && !flush) begin
      exp_t e;
      e.sel = in_sel;
      e.y   = in_y;
      e.f   = {in_neg, in_zero, in_cout, in_ovf};
      exp_q.push_back(e);
      $display("push y=%08h sel=%0h nzcv=%04b", in_y, in_sel, e.f);
    end
`ifdef ALU_OVF_STICKY_EN
    if (push && !flush && in_ovf) pend_sticky = 1'b1;
    else if (clr_sticky)          pend_sticky = 1'b0;
`else
    pend_sticky = 1'b0;
`endif
    last_flush = flush;
  endtask

  task automatic mid_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_count", {29'd0, count}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_flag_reg", {28'd0, flag_reg}, 32'd0);
    check("rst_sticky", {31'd0, ovf_sticky}, 32'd0);
    exp_q.delete();
    exp_flag    = '0;
    pend_sticky = 1'b0;
    last_flush  = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    // Phases: fill, stream at full, drain, mixed with flushes, sticky stress.
    for (int i = 0; i < 150; i++) begin @(posedge clk); #2 cycle(90, 10, 0, 5); end
    for (int i = 0; i < 300; i++) begin @(posedge clk); #2 cycle(95, 95, 0, 5); end
    for (int i = 0; i < 150; i++) begin @(posedge clk); #2 cycle(10, 90, 0, 5); end
    @(posedge clk); #2 mid_reset();
    for (int i = 0; i < 400; i++) begin @(posedge clk); #2 cycle(70, 55, 4, 10); end
    for (int i = 0; i < 100; i++) begin @(posedge clk); #2 cycle(80, 20, 0, 0); end
    @(posedge clk); #2 mid_reset();
    for (int i = 0; i < 300; i++) begin @(posedge clk); #2 cycle(60, 60, 2, 40); end
    for (int i = 0; i < 20; i++)  begin @(posedge clk); #2 cycle(0, 100, 0, 0); end
    @(posedge clk); #2 cycle(0, 0, 0, 0);
    vectors++;
    if (pops_seen < 100) begin
      miscompares++;
      $display("FAIL pop_activity: got %0d pops expected at least 100", pops_seen);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
